// File: rtl/a_cwrx_if.sv
`default_nettype none
// ============================================================================
//  Module   : a_cwrx_if
//  Brief    : Codeword valid/ready handshake bundle between receiver and decoder
//  Revision : 1.0 - initial release
// ============================================================================
interface a_cwrx_if #(
  parameter int CW_W = 9
);
  logic [CW_W-1:0] cw;
  logic            cw_valid;
  logic            cw_ready;

  modport master (
    output cw,
    output cw_valid,
    input  cw_ready
  );

  modport slave (
    input  cw,
    input  cw_valid,
    output cw_ready
  );
endinterface
`default_nettype wire

// File: rtl/a_cwrx.sv
`default_nettype none
// ============================================================================
//  Module   : a_cwrx
//  Brief    : Framed 1-wire serial codeword receiver with one-word output buffer
//  Revision : 1.0 - initial release
// ============================================================================
module a_cwrx #(
  parameter int BIT_CYCLES = 4,
  parameter int CW_W       = 9
) (
  input  wire logic clk,
  input  wire logic reset_n,
  input  wire logic i_rx_in,
  a_cwrx_if.master  m_cw,
  output logic      o_frm_err,
  output logic      o_ovf,
  output logic      o_busy
);

  localparam int CNT_W = $clog2(BIT_CYCLES);
  localparam int IDX_W = $clog2(CW_W);

  localparam logic [CNT_W-1:0] c_HALF_M1 = CNT_W'(BIT_CYCLES / 2 - 1);
  localparam logic [CNT_W-1:0] c_FULL_M1 = CNT_W'(BIT_CYCLES - 1);
  localparam logic [IDX_W-1:0] c_LAST    = IDX_W'(CW_W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t            r_state;
  logic              r_rx_m;
  logic              r_rx_s;
  logic [CNT_W-1:0]  r_cnt;
  logic [IDX_W-1:0]  r_idx;
  logic [CW_W-1:0]   r_sreg;
  logic              r_pend;
  logic [CW_W-1:0]   r_cw;
  logic              r_cw_valid;
  logic              r_frm_err;
  logic              r_ovf;
  logic              r_busy;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_rx_m     <= 1'b1;
      r_rx_s     <= 1'b1;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_sreg     <= '0;
      r_pend     <= 1'b0;
      r_cw       <= '0;
      r_cw_valid <= 1'b0;
      r_frm_err  <= 1'b0;
      r_ovf      <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_rx_m    <= i_rx_in;
      r_rx_s    <= r_rx_m;
      r_frm_err <= 1'b0;
      r_ovf     <= 1'b0;
      r_pend    <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (!r_rx_s) begin
            r_state <= S_START;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end

        S_START: begin
          if (r_cnt == c_HALF_M1) begin
            r_cnt <= '0;
            if (!r_rx_s) begin
              r_state <= S_DATA;
              r_idx   <= '0;
            end else begin
              // Start bit gone by mid-bit: treat as line noise.
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_DATA: begin
          if (r_cnt == c_FULL_M1) begin
            r_cnt  <= '0;
            r_sreg <= {r_sreg[CW_W-2:0], r_rx_s};
            r_idx  <= r_idx + IDX_W'(1);
            if (r_idx == c_LAST) begin
              r_state <= S_STOP;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_STOP: begin
          if (r_cnt == c_FULL_M1) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            if (r_rx_s) begin
              r_pend <= 1'b1;
            end else begin
              r_frm_err <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase

      // A word arriving while the buffer drains in the same cycle replaces it.
      if (r_pend) begin
        if (!r_cw_valid || m_cw.cw_ready) begin
          r_cw       <= r_sreg;
          r_cw_valid <= 1'b1;
        end else begin
          r_ovf <= 1'b1;
        end
      end else if (r_cw_valid && m_cw.cw_ready) begin
        r_cw_valid <= 1'b0;
      end
    end
  end

  assign m_cw.cw       = r_cw;
  assign m_cw.cw_valid = r_cw_valid;
  assign o_frm_err     = r_frm_err;
  assign o_ovf         = r_ovf;
  assign o_busy        = r_busy;

endmodule
`default_nettype wire
